// File: rtl/nn_seq_pkg.sv
// Shared types and helpers for the layer MAC sequencer.
package nn_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } seq_state_t;

    // Index width for a terminal count n; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX up-counter on the falling clock edge with synchronous clear.
module mod_counter #(
    parameter int unsigned MAX = 2,
    parameter int unsigned W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max
);

    // Terminal value is MAX-1, not the power-of-two limit of W.
    assign at_max = (count == W'(MAX - 1));

    // Count state: reset/clear to zero, otherwise step and wrap at the terminal count.
    always_ff @(negedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/layer_mac_sequencer.sv
// Walks N_IN inputs for each of N_OUT neurons, pulsing clear/done per neuron.
module layer_mac_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 ack,
    output logic                                 mac_en,
    output logic [nn_seq_pkg::idx_width(N_IN)-1:0]  in_idx,
    output logic [nn_seq_pkg::idx_width(N_OUT)-1:0] out_idx,
    output logic                                 clr_acc,
    output logic                                 neuron_done,
    output logic [nn_seq_pkg::idx_width(N_OUT)-1:0] out_idx_done,
    output logic                                 busy,
    output logic                                 ack_mac
);

    localparam int unsigned IN_W  = idx_width(N_IN);
    localparam int unsigned OUT_W = idx_width(N_OUT);

    seq_state_t state;
    logic       run;
    logic       launch;
    logic       in_inc;
    logic       out_inc;
    logic       in_at_max;
    logic       out_at_max;

    assign run     = (state == StRun);
    // start is only honoured outside RUN; it also masks any ack in that cycle.
    assign launch  = start && !run;
    assign in_inc  = run && ack;
    assign out_inc = in_inc && in_at_max;

    assign mac_en = run;
    assign busy   = run;

    mod_counter #(
        .MAX (N_IN),
        .W   (IN_W)
    ) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .inc    (in_inc),
        .count  (in_idx),
        .at_max (in_at_max)
    );

    mod_counter #(
        .MAX (N_OUT),
        .W   (OUT_W)
    ) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (launch),
        .inc    (out_inc),
        .count  (out_idx),
        .at_max (out_at_max)
    );

    // Sequencing FSM with registered pulse and status outputs.
    always_ff @(negedge clk) begin
        if (rst) begin
            state        <= StIdle;
            clr_acc      <= 1'b0;
            neuron_done  <= 1'b0;
            out_idx_done <= '0;
            ack_mac      <= 1'b0;
        end else begin
            clr_acc     <= 1'b0;
            neuron_done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state   <= StRun;
                        ack_mac <= 1'b0;
                        clr_acc <= 1'b1;
                    end
                end
                StRun: begin
                    if (ack && in_at_max) begin
                        neuron_done  <= 1'b1;
                        out_idx_done <= out_idx;
                        if (out_at_max) begin
                            state   <= StDone;
                            ack_mac <= 1'b1;
                        end else begin
                            clr_acc <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: a (3,2) and a (1,4) instance share stimulus and
// are checked every cycle against an accepted-ack counting model.
module tb_layer_mac_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ack = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: defaults N_IN=3, N_OUT=2
    logic       mac_en0, clr_acc0, neuron_done0, busy0, ack_mac0;
    logic [1:0] in_idx0;
    logic [0:0] out_idx0, out_idx_done0;

    // Instance 1: N_IN=1, N_OUT=4
    logic       mac_en1, clr_acc1, neuron_done1, busy1, ack_mac1;
    logic [0:0] in_idx1;
    logic [1:0] out_idx1, out_idx_done1;

    layer_mac_sequencer #(
        .N_IN  (3),
        .N_OUT (2)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ack          (ack),
        .mac_en       (mac_en0),
        .in_idx       (in_idx0),
        .out_idx      (out_idx0),
        .clr_acc      (clr_acc0),
        .neuron_done  (neuron_done0),
        .out_idx_done (out_idx_done0),
        .busy         (busy0),
        .ack_mac      (ack_mac0)
    );

    layer_mac_sequencer #(
        .N_IN  (1),
        .N_OUT (4)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ack          (ack),
        .mac_en       (mac_en1),
        .in_idx       (in_idx1),
        .out_idx      (out_idx1),
        .clr_acc      (clr_acc1),
        .neuron_done  (neuron_done1),
        .out_idx_done (out_idx_done1),
        .busy         (busy1),
        .ack_mac      (ack_mac1)
    );

    int tests = 0;
    int fails = 0;

    // Model: phase 0 idle, 1 run, 2 done; k = acks accepted in this layer.
    int m_ph[2];
    int m_k[2];
    int m_odone[2];
    bit m_clr[2];
    bit m_nd[2];

    function automatic int n_in_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic int n_out_of(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    task automatic model(input int d, input bit s, input bit a, input bit r);
        int ni, no;
        ni = n_in_of(d);
        no = n_out_of(d);
        m_clr[d] = 1'b0;
        m_nd[d]  = 1'b0;
        if (r) begin
            m_ph[d]    = 0;
            m_k[d]     = 0;
            m_odone[d] = 0;
        end else if (m_ph[d] != 1) begin
            if (s) begin
                m_ph[d]  = 1;
                m_k[d]   = 0;
                m_clr[d] = 1'b1;
            end
        end else if (a) begin
            m_k[d] = m_k[d] + 1;
            if (m_k[d] % ni == 0) begin
                m_nd[d]    = 1'b1;
                m_odone[d] = m_k[d] / ni - 1;
                if (m_k[d] == ni * no) m_ph[d] = 2;
                else m_clr[d] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("d0.in_idx", 32'(in_idx0), 32'(m_k[0] % 3));
        chk("d0.out_idx", 32'(out_idx0), 32'((m_k[0] / 3) % 2));
        chk("d0.clr_acc", 32'(clr_acc0), 32'(m_clr[0]));
        chk("d0.neuron_done", 32'(neuron_done0), 32'(m_nd[0]));
        chk("d0.out_idx_done", 32'(out_idx_done0), 32'(m_odone[0]));
        chk("d0.busy", 32'(busy0), 32'(m_ph[0] == 1));
        chk("d0.mac_en", 32'(mac_en0), 32'(m_ph[0] == 1));
        chk("d0.ack_mac", 32'(ack_mac0), 32'(m_ph[0] == 2));
        chk("d1.in_idx", 32'(in_idx1), 32'd0);
        chk("d1.out_idx", 32'(out_idx1), 32'(m_k[1] % 4));
        chk("d1.clr_acc", 32'(clr_acc1), 32'(m_clr[1]));
        chk("d1.neuron_done", 32'(neuron_done1), 32'(m_nd[1]));
        chk("d1.out_idx_done", 32'(out_idx_done1), 32'(m_odone[1]));
        chk("d1.busy", 32'(busy1), 32'(m_ph[1] == 1));
        chk("d1.mac_en", 32'(mac_en1), 32'(m_ph[1] == 1));
        chk("d1.ack_mac", 32'(ack_mac1), 32'(m_ph[1] == 2));
    endtask

    // Drive while clk is high, let the DUT update on the falling edge, check 1ns later.
    task automatic cycle(input bit s, input bit a, input bit r);
        start = s;
        ack   = a;
        rst   = r;
        @(negedge clk);
        model(0, s, a, r);
        model(1, s, a, r);
        #1;
        check_all();
        @(posedge clk);
    endtask

    initial begin
        @(posedge clk);

        // Reset state
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        // Start with ack held high throughout (ack on the start cycle is not counted)
        cycle(1, 1, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0);
        chk("d0.ack_mac_after_layer", 32'(ack_mac0), 32'd1);

        // Acks in DONE are ignored, then restart
        for (int i = 0; i < 5; i++) cycle(0, 1, 0);
        cycle(1, 0, 0);
        chk("d0.restart_clr", 32'(clr_acc0), 32'd1);

        // Alternating ack: six accepted acks needed for instance 0
        for (int i = 0; i < 14; i++) cycle(0, (i % 2) == 0, 0);

        // Reset mid-run at (in=1, out=1) for instance 0, then restart
        cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0);
        chk("d0.pre_reset_in", 32'(in_idx0), 32'd1);
        cycle(0, 1, 1);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0);

        // start reasserted during RUN at in_idx=2 is ignored
        cycle(0, 1, 1);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
